// File: rtl/cache_pkg.sv
// Shared defaults, derived widths and fill-sequencer state type for the cache data array.
// Holds no logic, so it adds no latency and applies no backpressure.
package cache_pkg;

  localparam int DEF_WAYS    = 4;
  localparam int DEF_SETS    = 1024;
  localparam int DEF_CHUNK_W = 128;
  localparam int DEF_CHUNKS  = 4;

  // Index width that never collapses to zero bits, so a 1-way build still has a way port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SET_W       = idx_w(DEF_SETS);
  localparam int WAY_W       = idx_w(DEF_WAYS);
  localparam int CHUNK_IDX_W = idx_w(DEF_CHUNKS);
  localparam int BE_W        = DEF_CHUNK_W / 8;

  typedef enum logic [0:0] {
    FILL_IDLE = 1'b0,
    FILL_BUSY = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cache_data_bank.sv
// One way of the data store: byte-enabled write, registered-address read, 2-edge read latency, no backpressure.
// Define CACHE_DATA_ARRAY_FWD_EN to merge a same-edge write into the read word (write-first behaviour).
module cache_data_bank
  import cache_pkg::*;
#(
  parameter int DEPTH = DEF_SETS * DEF_CHUNKS,
  parameter int WIDTH = DEF_CHUNK_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [idx_w(DEPTH)-1:0]    wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [WIDTH/8-1:0]         wr_be,
  input  logic                       rd_en,
  input  logic [idx_w(DEPTH)-1:0]    rd_addr,
  output logic [WIDTH-1:0]           rd_data
);

  localparam int AW = idx_w(DEPTH);
  localparam int BW = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    addr_q;
  logic             en_q;
  logic [WIDTH-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BW; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) addr_q <= rd_addr;
  end

`ifdef CACHE_DATA_ARRAY_FWD_EN
  // The array word is sampled before the write lands, so enabled bytes are patched in here.
  always_comb begin
    rd_word = mem[addr_q];
    if (we && (wr_addr == addr_q)) begin
      for (int b = 0; b < BW; b++) begin
        if (wr_be[b]) rd_word[b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
  end
`else
  assign rd_word = mem[addr_q];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      rd_data <= '0;
    end else begin
      en_q <= rd_en;
      if (en_q) rd_data <= rd_word;
    end
  end

endmodule

// File: rtl/cache_data_array.sv
// N-way cache data store: 2-cycle pipelined read of one chunk across all ways, byte-enabled write, line-fill sequencer.
// Reads never stall; a fill is accepted only when idle and yields to wr_en. Define CACHE_DATA_ARRAY_FWD_EN for write-to-read forwarding.
module cache_data_array
  import cache_pkg::*;
#(
  parameter int WAYS    = DEF_WAYS,
  parameter int SETS    = DEF_SETS,
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int CHUNKS  = DEF_CHUNKS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_en,
  input  logic [idx_w(SETS)-1:0]        rd_set,
  input  logic [idx_w(CHUNKS)-1:0]      rd_chunk,
  output logic                          rd_valid,
  output logic [WAYS*CHUNK_W-1:0]       rd_data,
  input  logic                          wr_en,
  input  logic [idx_w(SETS)-1:0]        wr_set,
  input  logic [idx_w(WAYS)-1:0]        wr_way,
  input  logic [idx_w(CHUNKS)-1:0]      wr_chunk,
  input  logic [CHUNK_W-1:0]            wr_data,
  input  logic [CHUNK_W/8-1:0]          wr_be,
  input  logic                          fill_valid,
  output logic                          fill_ready,
  input  logic [idx_w(SETS)-1:0]        fill_set,
  input  logic [idx_w(WAYS)-1:0]        fill_way,
  input  logic [CHUNKS*CHUNK_W-1:0]     fill_data,
  output logic                          fill_done,
  output logic                          busy
);

  localparam int SW  = idx_w(SETS);
  localparam int WW  = idx_w(WAYS);
  localparam int CIW = idx_w(CHUNKS);
  localparam int BW  = CHUNK_W / 8;
  localparam int AW  = SW + CIW;

  fill_state_e                state_q, state_d;
  logic [CIW-1:0]             cnt_q, cnt_d;
  logic                       done_d;
  logic [SW-1:0]              fset_q;
  logic [WW-1:0]              fway_q;
  logic [CHUNKS*CHUNK_W-1:0]  fline_q;
  logic                       accept;
  logic                       fill_wr;
  logic                       rd_v1_q;

  logic                       wr_any;
  logic [AW-1:0]              w_addr;
  logic [WW-1:0]              w_way;
  logic [CHUNK_W-1:0]         w_data;
  logic [BW-1:0]              w_be;

  assign fill_ready = (state_q == FILL_IDLE) && !rst;
  assign busy       = (state_q == FILL_BUSY);
  assign accept     = fill_valid && fill_ready;
  // The external write owns the single write port; reset aborts the chunk in flight.
  assign fill_wr    = busy && !wr_en && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (accept) begin
          state_d = FILL_BUSY;
          cnt_d   = '0;
        end
      end
      FILL_BUSY: begin
        if (fill_wr) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CIW'(CHUNKS - 1)) begin
            state_d = FILL_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL_IDLE;
      cnt_q     <= '0;
      fill_done <= 1'b0;
      rd_v1_q   <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fill_done <= done_d;
      rd_v1_q   <= rd_en;
      rd_valid  <= rd_v1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fset_q  <= fill_set;
      fway_q  <= fill_way;
      fline_q <= fill_data;
    end
  end

  always_comb begin
    w_addr = {fset_q, cnt_q};
    w_way  = fway_q;
    w_data = fline_q[cnt_q*CHUNK_W +: CHUNK_W];
    w_be   = '1;
    if (wr_en) begin
      w_addr = {wr_set, wr_chunk};
      w_way  = wr_way;
      w_data = wr_data;
      w_be   = wr_be;
    end
  end

  assign wr_any = wr_en || fill_wr;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_data_bank #(
      .DEPTH (SETS * CHUNKS),
      .WIDTH (CHUNK_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_any && (w_way == WW'(w))),
      .wr_addr (w_addr),
      .wr_data (w_data),
      .wr_be   (w_be),
      .rd_en   (rd_en),
      .rd_addr ({rd_set, rd_chunk}),
      .rd_data (rd_data[w*CHUNK_W +: CHUNK_W])
    );
  end

endmodule
